// File: rtl/mem_burst_adapter.sv
// Converts single-word core mem_read/mem_write requests into line-sized pmem bursts (read-modify-write for stores).
// Latency: read miss mem_resp 5 cycles after request, write 10 cycles (pmem_resp every cycle); LINE_BUF_EN read hit 1 cycle.
// Backpressure: bursts stall on missing pmem_resp; core holds its request until the one-cycle mem_resp pulse.
module mem_burst_adapter #(
    parameter int BEATS  = 4,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [3:0]        mem_byte_enable,
    input  logic [31:0]       mem_address,
    input  logic [31:0]       mem_wdata,
    output logic              mem_resp,
    output logic [31:0]       mem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [BEAT_W-1:0] pmem_wdata,
    input  logic [BEAT_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int LINE_W = BEATS * BEAT_W;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int WIDX_W = OFF_W - 2;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TAG_W  = 32 - OFF_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        MERGE    = 3'd2,
        WR_BURST = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_beat_cnt;
    logic [LINE_W-1:0]   r_line;
    logic [31:0]         r_addr;
    logic [WIDX_W-1:0]   r_word;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic                r_is_wr;
    logic                w_last;
    logic                w_hit;
    logic [31:0]         w_word;
    logic                w_unused;

    // Byte offset within a word never selects anything: the core moves whole words.
    assign w_unused = ^mem_address[1:0];

    assign w_last = (r_beat_cnt == CNT_W'(BEATS - 1));
    assign w_word = r_line[int'(r_word) * 32 +: 32];
    assign pmem_address = r_addr;

`ifdef LINE_BUF_EN
    logic             r_buf_vld;
    logic [TAG_W-1:0] r_buf_tag;

    assign w_hit = r_buf_vld && (r_buf_tag == mem_address[31:OFF_W]);

    // Line buffer tag: invalidated when a miss starts refilling the line, valid once the refill burst completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf_vld <= 1'b0;
            r_buf_tag <= '0;
        end else if (r_state == IDLE && (mem_read || mem_write) && !w_hit) begin
            r_buf_vld <= 1'b0;
        end else if (r_state == RD_BURST && pmem_resp && w_last) begin
            r_buf_vld <= 1'b1;
            r_buf_tag <= r_addr[31:OFF_W];
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    // State register plus request latches, beat counter and the line being assembled/merged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_line     <= '0;
            r_addr     <= '0;
            r_word     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_is_wr    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        r_addr     <= {mem_address[31:OFF_W], {OFF_W{1'b0}}};
                        r_word     <= mem_address[OFF_W-1:2];
                        r_be       <= mem_byte_enable;
                        r_wdata    <= mem_wdata;
                        // A simultaneous read+write is served as a write.
                        r_is_wr    <= mem_write;
                        r_beat_cnt <= '0;
                    end
                end
                RD_BURST: begin
                    if (pmem_resp) begin
                        r_line[int'(r_beat_cnt) * BEAT_W +: BEAT_W] <= pmem_rdata;
                        r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
                    end
                end
                MERGE: begin
                    for (int b = 0; b < 4; b++) begin
                        if (r_be[b]) begin
                            r_line[int'(r_word) * 32 + b * 8 +: 8] <= r_wdata[b * 8 +: 8];
                        end
                    end
                end
                WR_BURST: begin
                    if (pmem_resp) begin
                        r_beat_cnt <= w_last ? '0 : r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and all handshake outputs, which are pure functions of the current state.
    always_comb begin
        w_next     = r_state;
        mem_resp   = 1'b0;
        mem_rdata  = '0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (w_hit) begin
                        w_next = mem_write ? MERGE : RESP;
                    end else begin
                        w_next = RD_BURST;
                    end
                end
            end
            RD_BURST: begin
                pmem_read = 1'b1;
                if (pmem_resp && w_last) begin
                    w_next = r_is_wr ? MERGE : RESP;
                end
            end
            MERGE: begin
                w_next = WR_BURST;
            end
            WR_BURST: begin
                pmem_write = 1'b1;
                pmem_wdata = r_line[int'(r_beat_cnt) * BEAT_W +: BEAT_W];
                if (pmem_resp && w_last) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                mem_resp = 1'b1;
                if (!r_is_wr) begin
                    mem_rdata = w_word;
                end
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
